// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle ARM datapath: decode, NZCV flags, condition gating.
// Optional macro PERF_CNT_EN adds the CycleCnt/InstrCnt performance counter outputs.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstrCnt
`endif
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_NOP    = 4'd10;

  logic [3:0] state_r;
  logic [3:0] state_next_s;
  logic [3:0] flags_r;
  logic       cond_pass_r;

  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] cmd_s;
  logic       cmd_addsub_s;
  logic       exec_state_s;

  logic       pcwrite_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       adrsrc_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] alucontrol_s;
  logic [1:0] resultsrc_s;

  // ARM condition-code evaluation against {N,Z,C,V}; NV (1111) never passes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = c;
      4'b0011: cond_eval = ~c;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = c & ~z;
      4'b1001: cond_eval = ~(c & ~z);
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Data-processing cmd to ALU operation; unsupported commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = 2'b00;
      4'b0010: alu_decode = 2'b01;
      4'b0000: alu_decode = 2'b10;
      4'b1100: alu_decode = 2'b11;
      default: alu_decode = 2'b00;
    endcase
  endfunction

  assign cond_s       = Instr[19:16];
  assign op_s         = Instr[15:14];
  assign funct_s      = Instr[13:8];
  assign cmd_s        = funct_s[4:1];
  assign cmd_addsub_s = (cmd_s == 4'b0100) | (cmd_s == 4'b0010);
  assign exec_state_s = (state_r == S_EXECR) | (state_r == S_EXECI);

  // Next-state sequencing.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        case (op_s)
          2'b01:   state_next_s = S_MEMADR;
          2'b00:   state_next_s = funct_s[5] ? S_EXECI : S_EXECR;
          2'b10:   state_next_s = S_BRANCH;
          default: state_next_s = S_NOP;
        endcase
      end
      S_MEMADR: state_next_s = funct_s[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next_s = S_MEMWB;
      S_EXECR:  state_next_s = S_ALUWB;
      S_EXECI:  state_next_s = S_ALUWB;
      default:  state_next_s = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Condition result is frozen at the end of DECODE so later flag changes cannot affect gating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_pass_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      cond_pass_r <= cond_eval(cond_s, flags_r);
    end else begin
      cond_pass_r <= cond_pass_r;
    end
  end

  // NZCV update when an S-suffixed data-processing op executes; C/V only for ADD/SUB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (exec_state_s && cond_pass_r && funct_s[0]) begin
      flags_r[3:2] <= ALUFlags[3:2];
      flags_r[1:0] <= cmd_addsub_s ? ALUFlags[1:0] : flags_r[1:0];
    end else begin
      flags_r <= flags_r;
    end
  end

  // Moore per-state control decode; unlisted outputs stay 0.
  always_comb begin
    pcwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    adrsrc_s     = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    alucontrol_s = 2'b00;
    resultsrc_s  = 2'b00;
    case (state_r)
      S_FETCH: begin
        irwrite_s   = 1'b1;
        alusrca_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
        pcwrite_s   = 1'b1;
      end
      S_DECODE: begin
        alusrca_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
      end
      S_MEMADR: begin
        alusrcb_s = 2'b01;
      end
      S_MEMRD: begin
        adrsrc_s = 1'b1;
      end
      S_MEMWB: begin
        resultsrc_s = 2'b01;
        regwrite_s  = cond_pass_r;
      end
      S_MEMWR: begin
        adrsrc_s   = 1'b1;
        memwrite_s = cond_pass_r;
      end
      S_EXECR: begin
        alucontrol_s = alu_decode(cmd_s);
      end
      S_EXECI: begin
        alusrcb_s    = 2'b01;
        alucontrol_s = alu_decode(cmd_s);
      end
      S_ALUWB: begin
        regwrite_s = cond_pass_r;
      end
      S_BRANCH: begin
        alusrcb_s   = 2'b01;
        resultsrc_s = 2'b10;
        pcwrite_s   = cond_pass_r;
      end
      default: begin
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // Reset already holds the FSM in FETCH; write enables are additionally masked while it is high.
  assign PCWrite    = pcwrite_s  & ~reset;
  assign MemWrite   = memwrite_s & ~reset;
  assign IRWrite    = irwrite_s  & ~reset;
  assign RegWrite   = regwrite_s & ~reset;
  assign AdrSrc     = adrsrc_s;
  assign ALUSrcA    = alusrca_s;
  assign ALUSrcB    = alusrcb_s;
  assign ALUControl = alucontrol_s;
  assign ResultSrc  = resultsrc_s;
  assign ImmSrc     = op_s;
  assign RegSrc     = {(op_s == 2'b01) & ~funct_s[0], (op_s == 2'b10)};

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] instr_cnt_r;
  logic        instr_done_s;

  assign instr_done_s = (state_r == S_MEMWB) | (state_r == S_MEMWR) | (state_r == S_ALUWB) |
                        (state_r == S_BRANCH) | (state_r == S_NOP);

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_r <= 32'd0;
      instr_cnt_r <= 32'd0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
      instr_cnt_r <= instr_done_s ? (instr_cnt_r + 32'd1) : instr_cnt_r;
    end
  end

  assign CycleCnt = cycle_cnt_r;
  assign InstrCnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (default build, PERF_CNT_EN undefined).
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;

  int ncmp;
  int nfail;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Entered in FETCH; leaves the FSM in the first state after DECODE.
  task automatic do_fetch(input string tag, input logic [19:0] ins);
    Instr = ins;
    chk(tag, "fetch.pcwrite", 32'(PCWrite), 32'd1);
    chk(tag, "fetch.irwrite", 32'(IRWrite), 32'd1);
    chk(tag, "fetch.adrsrc", 32'(AdrSrc), 32'd0);
    tick();
    chk(tag, "decode.writes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    chk(tag, "decode.alusrcb", 32'(ALUSrcB), 32'd2);
    tick();
  endtask

  task automatic run_dp(input string tag, input logic [19:0] ins, input logic [3:0] aflags,
                        input logic imm, input logic [1:0] exp_alu, input logic exp_rw);
    do_fetch(tag, ins);
    chk(tag, "exec.alusrca", 32'(ALUSrcA), 32'd0);
    chk(tag, "exec.alusrcb", 32'(ALUSrcB), imm ? 32'd1 : 32'd0);
    chk(tag, "exec.alucontrol", 32'(ALUControl), 32'(exp_alu));
    ALUFlags = aflags;
    tick();
    chk(tag, "aluwb.regwrite", 32'(RegWrite), 32'(exp_rw));
    chk(tag, "aluwb.resultsrc", 32'(ResultSrc), 32'd0);
    ALUFlags = 4'b0000;
    tick();
    chk(tag, "back_in_fetch", 32'(PCWrite), 32'd1);
  endtask

  task automatic run_b(input string tag, input logic [19:0] ins, input logic exp_pcw);
    do_fetch(tag, ins);
    chk(tag, "branch.regsrc", 32'(RegSrc), 32'd1);
    chk(tag, "branch.alusrcb", 32'(ALUSrcB), 32'd1);
    chk(tag, "branch.pcwrite", 32'(PCWrite), 32'(exp_pcw));
    tick();
    chk(tag, "back_in_fetch", 32'(PCWrite), 32'd1);
  endtask

  initial begin
    ncmp     = 0;
    nfail    = 0;
    reset    = 1'b1;
    Instr    = 20'h00000;
    ALUFlags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "writes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
    chk("reset", "alusrca", 32'(ALUSrcA), 32'd1);
    chk("reset", "alusrcb", 32'(ALUSrcB), 32'd2);
    chk("reset", "resultsrc", 32'(ResultSrc), 32'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Data processing: ADD reg, ORR reg, AND imm, unsupported EOR.
    run_dp("add", 20'hE0821, 4'b1111, 1'b0, 2'b00, 1'b1);
    run_dp("orr", 20'hE1821, 4'b0000, 1'b0, 2'b11, 1'b1);
    run_dp("and_imm", 20'hE2021, 4'b0000, 1'b1, 2'b10, 1'b1);
    run_dp("eor", 20'hE0221, 4'b0000, 1'b0, 2'b00, 1'b1);

    // LDR: 5 cycles.
    do_fetch("ldr", 20'hE5921);
    chk("ldr", "regsrc", 32'(RegSrc), 32'd0);
    chk("ldr", "memadr.alusrcb", 32'(ALUSrcB), 32'd1);
    tick();
    chk("ldr", "memrd.adrsrc", 32'(AdrSrc), 32'd1);
    chk("ldr", "memrd.resultsrc", 32'(ResultSrc), 32'd0);
    tick();
    chk("ldr", "memwb.regwrite", 32'(RegWrite), 32'd1);
    chk("ldr", "memwb.resultsrc", 32'(ResultSrc), 32'd1);
    tick();
    chk("ldr", "back_in_fetch", 32'(PCWrite), 32'd1);

    // STR: 4 cycles.
    do_fetch("str", 20'hE5821);
    chk("str", "regsrc", 32'(RegSrc), 32'd2);
    tick();
    chk("str", "memwr.memwrite", 32'(MemWrite), 32'd1);
    chk("str", "memwr.adrsrc", 32'(AdrSrc), 32'd1);
    chk("str", "memwr.regwrite", 32'(RegWrite), 32'd0);
    tick();
    chk("str", "back_in_fetch", 32'(PCWrite), 32'd1);

    // Flags and conditional execution.
    run_dp("subs", 20'hE0521, 4'b0100, 1'b0, 2'b01, 1'b1);
    run_b("beq_z1", 20'h0A000, 1'b1);
    run_b("bne_z1", 20'h1A000, 1'b0);
    run_dp("addne_z1", 20'h10821, 4'b0000, 1'b0, 2'b00, 1'b0);
    run_b("beq_after_addne", 20'h0A000, 1'b1);
    run_dp("add_nv", 20'hF0821, 4'b0000, 1'b0, 2'b00, 1'b0);

    // Undefined op: 3 cycles, no writes.
    do_fetch("nop", 20'hEC000);
    chk("nop", "writes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
    tick();
    chk("nop", "back_in_fetch", 32'(PCWrite), 32'd1);

    // Reset in the middle of an LDR (MEMRD).
    do_fetch("ldr_rst", 20'hE5921);
    tick();
    chk("ldr_rst", "memrd.adrsrc", 32'(AdrSrc), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ldr_rst", "writes_masked", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
    chk("ldr_rst", "adrsrc_fetch", 32'(AdrSrc), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    run_b("beq_after_rst", 20'h0A000, 1'b0);
    run_b("bne_after_rst", 20'h1A000, 1'b1);

    // C/V load only for ADD/SUB: SUBS sets Z,C; ANDS then loads N,Z only -> NZCV=1010.
    run_dp("subs_zc", 20'hE0521, 4'b0110, 1'b0, 2'b01, 1'b1);
    run_b("bcs_after_subs", 20'h2A000, 1'b1);
    run_dp("ands", 20'hE0121, 4'b1001, 1'b0, 2'b10, 1'b1);
    run_b("bcs_after_ands", 20'h2A000, 1'b1);
    run_b("bmi_after_ands", 20'h4A000, 1'b1);
    run_b("bvs_after_ands", 20'h6A000, 1'b0);
    run_b("beq_after_ands", 20'h0A000, 1'b0);
    run_b("bge_after_ands", 20'hAA000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
